// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite initiator.
//   axil_mst_state_t : initiator FSM state encoding
//   AXI_RESP_*       : AXI response codes (passed through unmodified)
//   AXI_PROT_DEFAULT : protection attribute driven on awprot/arprot
package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } axil_mst_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator.
// Accepts one valid/ready command (write or read), runs it as one AXI-Lite
// transaction and returns the response on a valid/ready response port.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   cmd_*               : command in (we, addr, wdata, wstrb)
//   rsp_*               : response out (rdata, resp, we echo)
//   busy                : high whenever not IDLE
//   axil_aw*/w*/b*      : AXI-Lite write channels (master side)
//   axil_ar*/r*         : AXI-Lite read channels (master side)
// Every AXI output and cmd_ready is a function of flops only, so there is
// no combinational path from any AXI input to them.
module axil_master
  import axil_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_we,

  output logic              busy,

  output logic [ADDR_W-1:0] axil_awaddr,
  output logic [2:0]        axil_awprot,
  output logic              axil_awvalid,
  input  logic              axil_awready,
  output logic [DATA_W-1:0] axil_wdata,
  output logic [STRB_W-1:0] axil_wstrb,
  output logic              axil_wvalid,
  input  logic              axil_wready,
  input  logic [1:0]        axil_bresp,
  input  logic              axil_bvalid,
  output logic              axil_bready,

  output logic [ADDR_W-1:0] axil_araddr,
  output logic [2:0]        axil_arprot,
  output logic              axil_arvalid,
  input  logic              axil_arready,
  input  logic [DATA_W-1:0] axil_rdata,
  input  logic [1:0]        axil_rresp,
  input  logic              axil_rvalid,
  output logic              axil_rready
);

  axil_mst_state_t   state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              we_q, we_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;

  // Completion of each write channel, counting a handshake in this cycle.
  logic aw_fin, w_fin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      we_q        <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      we_q        <= we_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    we_d        = we_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    aw_fin      = aw_done_q | (axil_awvalid & axil_awready);
    w_fin       = w_done_q  | (axil_wvalid  & axil_wready);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          we_d      = cmd_we;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_we ? ST_WR : ST_RD_ADDR;
        end
      end
      ST_WR: begin
        // AW and W retire independently; leave only once both are done.
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (axil_bvalid) begin
          rsp_resp_d  = axil_bresp;
          rsp_rdata_d = '0;
          state_d     = ST_RSP;
        end
      end
      ST_RD_ADDR: begin
        if (axil_arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (axil_rvalid) begin
          rsp_rdata_d = axil_rdata;
          rsp_resp_d  = axil_rresp;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign rsp_valid    = (state_q == ST_RSP);
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_resp     = rsp_resp_q;
  assign rsp_we       = we_q;

  assign axil_awaddr  = addr_q;
  assign axil_awprot  = AXI_PROT_DEFAULT;
  assign axil_awvalid = (state_q == ST_WR) & ~aw_done_q;
  assign axil_wdata   = wdata_q;
  assign axil_wstrb   = wstrb_q;
  assign axil_wvalid  = (state_q == ST_WR) & ~w_done_q;
  assign axil_bready  = (state_q == ST_WR_RESP);

  assign axil_araddr  = addr_q;
  assign axil_arprot  = AXI_PROT_DEFAULT;
  assign axil_arvalid = (state_q == ST_RD_ADDR);
  assign axil_rready  = (state_q == ST_RD_DATA);

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master with a small behavioural CSR slave
// (0x0 reset 0, 0x4 reset 0x100, 0x8 reset 0xDEADBEEF, 0xC reset 0) whose
// AW/W ready can be delayed and whose read response code can be forced.
module tb_axil_master;
  import axil_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid, rsp_we, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axil_master #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_we(rsp_we), .busy(busy),
    .axil_awaddr(awaddr), .axil_awprot(awprot), .axil_awvalid(awvalid),
    .axil_awready(awready), .axil_wdata(wdata), .axil_wstrb(wstrb),
    .axil_wvalid(wvalid), .axil_wready(wready), .axil_bresp(bresp),
    .axil_bvalid(bvalid), .axil_bready(bready),
    .axil_araddr(araddr), .axil_arprot(arprot), .axil_arvalid(arvalid),
    .axil_arready(arready), .axil_rdata(rdata), .axil_rresp(rresp),
    .axil_rvalid(rvalid), .axil_rready(rready)
  );

  int total = 0, bad = 0;

  // ---------------- behavioural slave ----------------
  int          aw_dly = 0, w_dly = 0;
  int          aw_cnt, w_cnt;
  logic [1:0]  rresp_force = 2'b00;
  logic [31:0] mem [4];
  logic        aw_got, w_got;
  logic [15:0] aw_a;
  logic [31:0] w_d;
  logic [3:0]  w_s;

  wire aw_hs = awvalid && awready;
  wire w_hs  = wvalid && wready;
  wire [15:0] cur_a = aw_hs ? awaddr : aw_a;
  wire [31:0] cur_d = w_hs ? wdata : w_d;
  wire [3:0]  cur_s = w_hs ? wstrb : w_s;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = arvalid;
  assign bresp   = AXI_RESP_OKAY;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
      bvalid <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= '0;
      aw_a <= '0; w_d <= '0; w_s <= '0;
      mem[0] <= 32'h0; mem[1] <= 32'h100; mem[2] <= 32'hDEAD_BEEF; mem[3] <= 32'h0;
    end else begin
      if (aw_hs) begin aw_got <= 1'b1; aw_a <= awaddr; aw_cnt <= 0; end
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; w_cnt <= 0; end
      else if (wvalid) w_cnt <= w_cnt + 1;
      if (bvalid && bready) bvalid <= 1'b0;
      if ((aw_got || aw_hs) && (w_got || w_hs) && !bvalid) begin
        for (int i = 0; i < 4; i++)
          if (cur_s[i]) mem[cur_a[3:2]][8*i +: 8] <= cur_d[8*i +: 8];
        bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1; rdata <= mem[araddr[3:2]]; rresp <= rresp_force;
      end else if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- monitors ----------------
  int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, awv_n = 0, wv_n = 0;
  int stab_bad = 0, rsp_n = 0, cmd_n = 0;
  logic        awv_p = 1'b0, wv_p = 1'b0;
  logic [15:0] awa_p = '0;
  logic [31:0] wd_p = '0;

  always @(posedge clk) begin
    if (aw_hs) aw_hs_n <= aw_hs_n + 1;
    if (w_hs) w_hs_n <= w_hs_n + 1;
    if (bvalid && bready) b_hs_n <= b_hs_n + 1;
    if (awvalid) awv_n <= awv_n + 1;
    if (wvalid) wv_n <= wv_n + 1;
    if (rsp_valid && rsp_ready) rsp_n <= rsp_n + 1;
    if (cmd_valid && cmd_ready) cmd_n <= cmd_n + 1;
    // a valid still pending from the last cycle must be present with same payload
    if ((awv_p && (!awvalid || awaddr != awa_p)) || (wv_p && (!wvalid || wdata != wd_p)))
      stab_bad <= stab_bad + 1;
    awv_p <= awvalid && !awready; awa_p <= awaddr;
    wv_p  <= wvalid && !wready;   wd_p  <= wdata;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic we, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // lat counts cycles from the acceptance edge to the first rsp_valid cycle.
  task automatic collect(input int hold, output logic [31:0] rd, output logic [1:0] rs,
                         output logic w, output int lat);
    int sb = 0;
    logic [31:0] d0;
    logic [1:0]  r0;
    lat = 1;
    while (!rsp_valid && lat < 60) begin @(negedge clk); lat++; end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    d0 = rsp_rdata; r0 = rsp_resp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== d0 || rsp_resp !== r0 || cmd_ready !== 1'b0) sb++;
    end
    if (hold > 0) chk("rsp_hold_stable", sb, 0);
    rd = rsp_rdata; rs = rsp_resp; w = rsp_we;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd, d;
    logic [1:0]  rs;
    logic        w;
    int          lat, b0, aw0, w0, r0, c0, sb0;

    #3;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy}, 0);
    chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_we}, 0);
    chk("rst_axi_payload", {awaddr, araddr}, 0);
    chk("rst_wdata_wstrb", {wdata ^ 32'h0, 28'h0, wstrb}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // CSR read / write / read-back
    issue(1'b0, 16'h4, 32'h0, 4'h0);
    chk("rd_busy", {busy, cmd_ready}, 2'b10);
    collect(0, rd, rs, w, lat);
    chk("rd4_data", rd, 32'h0000_0100);
    chk("rd4_resp", rs, AXI_RESP_OKAY);
    chk("rd4_we", w, 0);
    chk("rd4_lat", lat, 3);
    chk("prot", {awprot, arprot}, 0);

    issue(1'b1, 16'h4, 32'h0000_1234, 4'hF);
    collect(0, rd, rs, w, lat);
    chk("wr4_resp", rs, AXI_RESP_OKAY);
    chk("wr4_rdata_zero", rd, 0);
    chk("wr4_we", w, 1);
    chk("wr4_lat", lat, 3);
    chk("idle_after_rsp", cmd_ready, 1);

    issue(1'b0, 16'h4, 32'h0, 4'h0);
    collect(0, rd, rs, w, lat);
    chk("rd4_back", rd, 32'h0000_1234);

    // partial strobe
    issue(1'b1, 16'h0, 32'hAABB_CCDD, 4'h2);
    collect(0, rd, rs, w, lat);
    issue(1'b0, 16'h0, 32'h0, 4'h0);
    collect(0, rd, rs, w, lat);
    chk("strb_partial", rd, 32'h0000_CC00);

    // skew: AW late
    aw_dly = 3; w_dly = 0;
    b0 = b_hs_n; aw0 = awv_n; w0 = wv_n; sb0 = stab_bad;
    issue(1'b1, 16'hC, 32'h1111_2222, 4'hF);
    collect(0, rd, rs, w, lat);
    chk("skewaw_awv_cycles", awv_n - aw0, 4);
    chk("skewaw_wv_cycles", wv_n - w0, 1);
    chk("skewaw_b_count", b_hs_n - b0, 1);
    chk("skewaw_lat", lat, 6);
    chk("skewaw_stable", stab_bad - sb0, 0);

    // skew: W late
    aw_dly = 0; w_dly = 3;
    b0 = b_hs_n; aw0 = awv_n; w0 = wv_n;
    issue(1'b1, 16'hC, 32'h3333_4444, 4'hF);
    collect(0, rd, rs, w, lat);
    chk("skeww_awv_cycles", awv_n - aw0, 1);
    chk("skeww_wv_cycles", wv_n - w0, 4);
    chk("skeww_b_count", b_hs_n - b0, 1);
    chk("skeww_lat", lat, 6);
    chk("skeww_stable", stab_bad - sb0, 0);
    w_dly = 0;
    issue(1'b0, 16'hC, 32'h0, 4'h0);
    collect(0, rd, rs, w, lat);
    chk("skew_readback", rd, 32'h3333_4444);

    // error response with response backpressure
    rresp_force = AXI_RESP_SLVERR;
    issue(1'b0, 16'h4, 32'h0, 4'h0);
    collect(5, rd, rs, w, lat);
    chk("err_resp", rs, AXI_RESP_SLVERR);
    chk("err_rdata", rd, 32'h0000_1234);
    rresp_force = AXI_RESP_OKAY;

    // reset mid-write
    aw_dly = 5; w_dly = 5;
    b0 = b_hs_n; r0 = rsp_n;
    issue(1'b1, 16'h4, 32'h5555_5555, 4'hF);
    chk("mid_awvalid_before", awvalid, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy}, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    aw_dly = 0; w_dly = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_no_b_rsp", {b_hs_n - b0, rsp_n - r0}, 0);
    issue(1'b0, 16'h8, 32'h0, 4'h0);
    collect(0, rd, rs, w, lat);
    chk("post_rst_rd8", rd, 32'hDEAD_BEEF);
    chk("post_rst_rd8_resp", rs, AXI_RESP_OKAY);

    // back-to-back alternating write/read
    r0 = rsp_n; c0 = cmd_n;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      issue(1'b1, 16'h0, d, 4'hF);
      collect(0, rd, rs, w, lat);
      issue(1'b0, 16'h0, 32'h0, 4'h0);
      collect(0, rd, rs, w, lat);
      chk("b2b_rd", rd, d);
    end
    chk("b2b_rsp_count", rsp_n - r0, 16);
    chk("b2b_cmd_count", cmd_n - c0, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
